// File: rtl/phase_arbiter.sv
// Two-requester arbiter in front of a shared, in-order phase unit; routes results back by tag.
// Optional build macro PHASE_ARB_FIXED_PRIO_EN: requester 0 always wins instead of round-robin.
module phase_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,

  input  logic [DATA_WIDTH-1:0] req0_i,
  input  logic [DATA_WIDTH-1:0] req0_q,
  input  logic                  req0_stb,
  input  logic [DATA_WIDTH-1:0] req1_i,
  input  logic [DATA_WIDTH-1:0] req1_q,
  input  logic                  req1_stb,

  output logic [DATA_WIDTH-1:0] rsp0_phase,
  output logic                  rsp0_stb,
  output logic [DATA_WIDTH-1:0] rsp1_phase,
  output logic                  rsp1_stb,

  output logic [DATA_WIDTH-1:0] phase_in_i,
  output logic [DATA_WIDTH-1:0] phase_in_q,
  output logic                  phase_in_stb,
  input  logic [DATA_WIDTH-1:0] phase_out,
  input  logic                  phase_out_stb,

  output logic [1:0]            drop,
  output logic                  fifo_err
);

  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);

  typedef logic [AW:0] ptr_t;

  // Per-requester views of the operand ports
  logic [1:0]            req_stb;
  logic [DATA_WIDTH-1:0] req_re [2];
  logic [DATA_WIDTH-1:0] req_im [2];

  assign req_stb   = {req1_stb, req0_stb};
  assign req_re[0] = req0_i;
  assign req_re[1] = req1_i;
  assign req_im[0] = req0_q;
  assign req_im[1] = req1_q;

  // Pending operand registers
  logic [1:0]            pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_re_q [2];
  logic [DATA_WIDTH-1:0] pend_re_d [2];
  logic [DATA_WIDTH-1:0] pend_im_q [2];
  logic [DATA_WIDTH-1:0] pend_im_d [2];
  logic [1:0]            drop_q, drop_d;

  // Tag FIFO
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic tag_mem_q [MAX_OUTSTANDING];
  logic fifo_full, fifo_empty;
  logic pop, pop_tag;
  logic fifo_err_q, fifo_err_d;

  // Grant
  logic       grant_valid;
  logic       grant_id;
  logic [1:0] grant;

  // Registered outputs
  logic                  phase_in_stb_q, phase_in_stb_d;
  logic [DATA_WIDTH-1:0] phase_in_re_q, phase_in_re_d;
  logic [DATA_WIDTH-1:0] phase_in_im_q, phase_in_im_d;
  logic [1:0]            rsp_stb_q, rsp_stb_d;
  logic [DATA_WIDTH-1:0] rsp_phase_q [2];
  logic [DATA_WIDTH-1:0] rsp_phase_d [2];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign grant_valid = enable && !fifo_full && (|pend_valid_q);

`ifdef PHASE_ARB_FIXED_PRIO_EN
  assign grant_id = ~pend_valid_q[0];
`else
  // last_q remembers the most recent winner; resets to 1 so requester 0 wins first
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant_valid) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign grant_id = (&pend_valid_q) ? ~last_q : pend_valid_q[1];
`endif

  assign grant[0] = grant_valid && !grant_id;
  assign grant[1] = grant_valid &&  grant_id;

  // Pending registers: a load on the grant edge keeps the new operand without flagging a drop
  always_comb begin
    pend_valid_d = pend_valid_q;
    drop_d       = drop_q;
    for (int x = 0; x < 2; x++) begin
      pend_re_d[x] = pend_re_q[x];
      pend_im_d[x] = pend_im_q[x];
      if (req_stb[x]) begin
        pend_valid_d[x] = 1'b1;
        pend_re_d[x]    = req_re[x];
        pend_im_d[x]    = req_im[x];
        if (pend_valid_q[x] && !grant[x]) begin
          drop_d[x] = 1'b1;
        end
      end else if (grant[x]) begin
        pend_valid_d[x] = 1'b0;
      end
    end
  end

  // Operand issue to the phase unit
  always_comb begin
    phase_in_stb_d = grant_valid;
    phase_in_re_d  = phase_in_re_q;
    phase_in_im_d  = phase_in_im_q;
    if (grant_valid) begin
      phase_in_re_d = grant_id ? pend_re_q[1] : pend_re_q[0];
      phase_in_im_d = grant_id ? pend_im_q[1] : pend_im_q[0];
    end
  end

  // FIFO pointers and result routing; results are routed even while enable is low
  assign pop     = phase_out_stb && !fifo_empty;
  assign pop_tag = tag_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_err_d = fifo_err_q;
    if (grant_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (phase_out_stb && fifo_empty) begin
      fifo_err_d = 1'b1;
    end
  end

  always_comb begin
    rsp_stb_d[0]   = pop && !pop_tag;
    rsp_stb_d[1]   = pop &&  pop_tag;
    rsp_phase_d[0] = rsp_stb_d[0] ? phase_out : rsp_phase_q[0];
    rsp_phase_d[1] = rsp_stb_d[1] ? phase_out : rsp_phase_q[1];
  end

  always_ff @(posedge clock) begin
    if (grant_valid) begin
      tag_mem_q[wr_ptr_q[AW-1:0]] <= grant_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q   <= '0;
      pend_re_q[0]   <= '0;
      pend_re_q[1]   <= '0;
      pend_im_q[0]   <= '0;
      pend_im_q[1]   <= '0;
      drop_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_err_q     <= 1'b0;
      phase_in_stb_q <= 1'b0;
      phase_in_re_q  <= '0;
      phase_in_im_q  <= '0;
      rsp_stb_q      <= '0;
      rsp_phase_q[0] <= '0;
      rsp_phase_q[1] <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_re_q[0]   <= pend_re_d[0];
      pend_re_q[1]   <= pend_re_d[1];
      pend_im_q[0]   <= pend_im_d[0];
      pend_im_q[1]   <= pend_im_d[1];
      drop_q         <= drop_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_err_q     <= fifo_err_d;
      phase_in_stb_q <= phase_in_stb_d;
      phase_in_re_q  <= phase_in_re_d;
      phase_in_im_q  <= phase_in_im_d;
      rsp_stb_q      <= rsp_stb_d;
      rsp_phase_q[0] <= rsp_phase_d[0];
      rsp_phase_q[1] <= rsp_phase_d[1];
    end
  end

  assign phase_in_stb = phase_in_stb_q;
  assign phase_in_i   = phase_in_re_q;
  assign phase_in_q   = phase_in_im_q;
  assign rsp0_stb     = rsp_stb_q[0];
  assign rsp1_stb     = rsp_stb_q[1];
  assign rsp0_phase   = rsp_phase_q[0];
  assign rsp1_phase   = rsp_phase_q[1];
  assign drop         = drop_q;
  assign fifo_err     = fifo_err_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter: directed vector table, corner sequences, random traffic.
module tb_phase_arbiter;

  localparam int unsigned MAXO = 16;
  localparam int unsigned DW   = 32;

  logic          clock = 1'b0;
  logic          reset, enable;
  logic [DW-1:0] req0_i, req0_q, req1_i, req1_q;
  logic          req0_stb, req1_stb;
  logic [DW-1:0] rsp0_phase, rsp1_phase, phase_in_i, phase_in_q, phase_out;
  logic          rsp0_stb, rsp1_stb, phase_in_stb, phase_out_stb;
  logic [1:0]    drop;
  logic          fifo_err;

  always #5 clock = ~clock;

  phase_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .req0_i       (req0_i),
    .req0_q       (req0_q),
    .req0_stb     (req0_stb),
    .req1_i       (req1_i),
    .req1_q       (req1_q),
    .req1_stb     (req1_stb),
    .rsp0_phase   (rsp0_phase),
    .rsp0_stb     (rsp0_stb),
    .rsp1_phase   (rsp1_phase),
    .rsp1_stb     (rsp1_stb),
    .phase_in_i   (phase_in_i),
    .phase_in_q   (phase_in_q),
    .phase_in_stb (phase_in_stb),
    .phase_out    (phase_out),
    .phase_out_stb(phase_out_stb),
    .drop         (drop),
    .fifo_err     (fifo_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending slots, a queue of in-flight tags, last winner
  bit            m_pv[2];
  logic [DW-1:0] m_pi[2];
  logic [DW-1:0] m_pq[2];
  int            m_last;
  int            m_tags[$];
  logic [1:0]    m_drop;
  logic          m_err;
  bit            e_pin_stb;
  logic [DW-1:0] e_pin_i, e_pin_q;
  bit            e_rsp_stb[2];
  logic [DW-1:0] e_rsp_ph[2];

  task automatic model_step();
    bit            g, granted;
    int            w, t;
    bit            rs[2];
    logic [DW-1:0] ri[2];
    logic [DW-1:0] rq[2];
    rs[0] = req0_stb; rs[1] = req1_stb;
    ri[0] = req0_i;   ri[1] = req1_i;
    rq[0] = req0_q;   rq[1] = req1_q;
    if (reset) begin
      m_pv = '{0, 0};
      m_tags.delete();
      m_last = 1;
      m_drop = 2'b00;
      m_err = 1'b0;
      e_pin_stb = 0;
      e_pin_i = '0;
      e_pin_q = '0;
      e_rsp_stb = '{0, 0};
      e_rsp_ph[0] = '0;
      e_rsp_ph[1] = '0;
      return;
    end
    g = enable && (m_tags.size() < MAXO) && (m_pv[0] || m_pv[1]);
    if (m_pv[0] && m_pv[1]) begin
`ifdef PHASE_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = 1 - m_last;
`endif
    end else begin
      w = m_pv[0] ? 0 : 1;
    end
    e_pin_stb = g;
    if (g) begin
      e_pin_i = m_pi[w];
      e_pin_q = m_pq[w];
      m_last  = w;
    end
    e_rsp_stb = '{0, 0};
    if (phase_out_stb) begin
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        e_rsp_stb[t] = 1;
        e_rsp_ph[t]  = phase_out;
      end else begin
        m_err = 1'b1;
      end
    end
    if (g) m_tags.push_back(w);
    for (int x = 0; x < 2; x++) begin
      granted = g && (w == x);
      if (rs[x]) begin
        if (m_pv[x] && !granted) m_drop[x] = 1'b1;
        m_pv[x] = 1;
        m_pi[x] = ri[x];
        m_pq[x] = rq[x];
      end else if (granted) begin
        m_pv[x] = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("m_pin_stb", phase_in_stb, e_pin_stb);
    check("m_pin_i", phase_in_i, e_pin_i);
    check("m_pin_q", phase_in_q, e_pin_q);
    check("m_rsp0_stb", rsp0_stb, e_rsp_stb[0]);
    check("m_rsp1_stb", rsp1_stb, e_rsp_stb[1]);
    check("m_rsp0_phase", rsp0_phase, e_rsp_ph[0]);
    check("m_rsp1_phase", rsp1_phase, e_rsp_ph[1]);
    check("m_drop", drop, m_drop);
    check("m_fifo_err", fifo_err, m_err);
  endtask

  // Inputs change only at the falling edge; outputs are compared there too
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_model();
  endtask

  task automatic drive(input bit rst, input bit en, input bit s0, input logic [DW-1:0] i0,
                       input logic [DW-1:0] q0, input bit s1, input logic [DW-1:0] i1,
                       input logic [DW-1:0] q1, input bit ps, input logic [DW-1:0] po);
    reset = rst; enable = en;
    req0_stb = s0; req0_i = i0; req0_q = q0;
    req1_stb = s1; req1_i = i1; req1_q = q1;
    phase_out_stb = ps; phase_out = po;
  endtask

  typedef struct {
    bit            rst, en, s0, s1, ps;
    logic [DW-1:0] i0, q0, i1, q1, po;
    bit            e_ps, e_r0, e_r1, e_err;
    logic [DW-1:0] e_pi, e_pq, e_r0p;
    logic [1:0]    e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit rst, input bit en, input bit s0, input logic [DW-1:0] i0,
                      input logic [DW-1:0] q0, input bit s1, input logic [DW-1:0] i1,
                      input logic [DW-1:0] q1, input bit ps, input logic [DW-1:0] po,
                      input bit eps, input logic [DW-1:0] epi, input logic [DW-1:0] epq,
                      input bit er0, input logic [DW-1:0] er0p, input bit er1,
                      input logic [1:0] edr, input bit eer);
    vec_t v;
    v.rst = rst; v.en = en; v.s0 = s0; v.i0 = i0; v.q0 = q0;
    v.s1 = s1; v.i1 = i1; v.q1 = q1; v.ps = ps; v.po = po;
    v.e_ps = eps; v.e_pi = epi; v.e_pq = epq; v.e_r0 = er0; v.e_r0p = er0p;
    v.e_r1 = er1; v.e_drop = edr; v.e_err = eer;
    vecs.push_back(v);
  endtask

  int            cnt;
  bit            any_rsp;
  logic [DW-1:0] obs[$];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst en s0 i0 q0 s1 i1 q1 ps po | pin_stb pin_i pin_q r0 r0ph r1 drop err
    addv(1, 0, 0, 0,   0,   0, 0,  0, 0, 0,    0, 0,   0,   0, 0,   0, 2'b00, 0);
    addv(0, 1, 1, 100, -50, 0, 0,  0, 0, 0,    0, 0,   0,   0, 0,   0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    1, 100, -50, 0, 0,   0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 100, -50, 0, 0,   0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 100, -50, 0, 0,   0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 100, -50, 0, 0,   0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 1, 777,  0, 100, -50, 1, 777, 0, 2'b00, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 100, -50, 0, 777, 0, 2'b00, 0);
    addv(1, 0, 0, 0,   0,   0, 0,  0, 0, 0,    0, 0,   0,   0, 0,   0, 2'b00, 0);
    addv(0, 0, 0, 0,   0,   1, 11, 1, 0, 0,    0, 0,   0,   0, 0,   0, 2'b00, 0);
    addv(0, 0, 0, 0,   0,   1, 22, 2, 0, 0,    0, 0,   0,   0, 0,   0, 2'b10, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    1, 22,  2,   0, 0,   0, 2'b10, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 22,  2,   0, 0,   0, 2'b10, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 0, 0,    0, 22,  2,   0, 0,   0, 2'b10, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 1, 5,    0, 22,  2,   0, 0,   1, 2'b10, 0);
    addv(0, 1, 0, 0,   0,   0, 0,  0, 1, 6,    0, 22,  2,   0, 0,   0, 2'b10, 1);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].s0, vecs[k].i0, vecs[k].q0,
            vecs[k].s1, vecs[k].i1, vecs[k].q1, vecs[k].ps, vecs[k].po);
      tick();
      check($sformatf("v%0d_pin_stb", k), phase_in_stb, vecs[k].e_ps);
      check($sformatf("v%0d_pin_i", k), phase_in_i, vecs[k].e_pi);
      check($sformatf("v%0d_pin_q", k), phase_in_q, vecs[k].e_pq);
      check($sformatf("v%0d_rsp0_stb", k), rsp0_stb, vecs[k].e_r0);
      check($sformatf("v%0d_rsp0_phase", k), rsp0_phase, vecs[k].e_r0p);
      check($sformatf("v%0d_rsp1_stb", k), rsp1_stb, vecs[k].e_r1);
      check($sformatf("v%0d_drop", k), drop, vecs[k].e_drop);
      check($sformatf("v%0d_fifo_err", k), fifo_err, vecs[k].e_err);
    end

    // Contention: both request together, four times, spacing 4
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    obs.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) drive(0, 1, 1, 32'h100 + r, 7, 1, 32'h200 + r, 9, 0, 0);
        else        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        if (phase_in_stb) obs.push_back(phase_in_i);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (phase_in_stb) obs.push_back(phase_in_i);
    end
    check("cont_grants", obs.size(), 8);
    for (int k = 0; k < 8 && k < obs.size(); k++)
      check($sformatf("cont_order%0d", k), obs[k], (k % 2 == 0) ? 32'h100 + k / 2 : 32'h200 + k / 2);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1000 + k);
      tick();
      check($sformatf("cont_rsp0_%0d", k), rsp0_stb, (k % 2 == 0));
      check($sformatf("cont_rsp1_%0d", k), rsp1_stb, (k % 2 == 1));
    end

    // Full FIFO: 17 back-to-back requests with the phase unit stalled
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cnt = 0;
    for (int k = 0; k < 17; k++) begin
      drive(0, 1, 1, k, 0, 0, 0, 0, 0, 0);
      tick();
      if (phase_in_stb) cnt++;
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (phase_in_stb) cnt++;
    end
    check("full_grants", cnt, 16);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    tick();
    check("full_pop_edge_stb", phase_in_stb, 0);
    check("full_pop_rsp0", rsp0_stb, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("full_17th_stb", phase_in_stb, 1);
    check("full_17th_i", phase_in_i, 16);
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, k);
      tick();
    end

    // Reset with three in flight, then late results
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, k < 3, 32'h30 + k, 1, 0, 0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_pin_stb", phase_in_stb, 0);
    check("rst_pin_i", phase_in_i, 0);
    check("rst_rsp1_phase", rsp1_phase, 0);
    check("rst_err", fifo_err, 0);
    any_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hdead + k);
      tick();
      any_rsp |= rsp0_stb | rsp1_stb;
    end
    check("late_err", fifo_err, 1);
    check("late_no_rsp", any_rsp, 0);

    // Random traffic against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 2) == 0, $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom, $urandom,
            (m_tags.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0),
            $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
